// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register index map and
// width helpers used to size ID and thread-index ports.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    IC_MASK     = 3'd0,
    IC_TRIGGER  = 3'd1,
    IC_POLARITY = 3'd2,
    IC_ACK      = 3'd3,
    IC_PENDING  = 3'd4,
    IC_SW_SET   = 3'd5,
    IC_CLAIM    = 3'd6
  } ic_reg_e;

  localparam logic [31:0] IC_NONE = 32'hffff_ffff;

  // Index width for n items; never zero so single-item configs still have a port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interrupt_sync.sv
// N-bit multi-flop synchroniser for asynchronous request lines.
// Ports: clk, reset (async, active-high), d (raw input), q (synchronised).
module interrupt_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// Per-core interrupt controller: synchronises external lines, applies
// per-line polarity and trigger mode, latches edges and software requests
// per thread, and reports the lowest-numbered unmasked pending line.
// Ports:
//   clk, reset            core clock, async active-high reset
//   interrupt_req         raw external lines (asynchronous)
//   ic_write_en/read_en   register strobes, ic_reg selects register,
//   ic_thread_idx         target thread for per-thread registers
//   ic_write_val          write data, ic_read_val registered read data
//   ic_interrupt_pending  per-thread any-pending flag
//   ic_interrupt_id       per-thread winning interrupt ID
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_INTERRUPTS = 16,
  parameter int NUM_THREADS    = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ID_WIDTH       = id_width(NUM_INTERRUPTS),
  parameter int THREAD_W       = id_width(NUM_THREADS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INTERRUPTS-1:0]            interrupt_req,
  input  logic                                 ic_write_en,
  input  logic                                 ic_read_en,
  input  logic [2:0]                           ic_reg,
  input  logic [THREAD_W-1:0]                  ic_thread_idx,
  input  logic [31:0]                          ic_write_val,
  output logic [31:0]                          ic_read_val,
  output logic [NUM_THREADS-1:0]               ic_interrupt_pending,
  output logic [NUM_THREADS-1:0][ID_WIDTH-1:0] ic_interrupt_id
);

  localparam int N  = NUM_INTERRUPTS;
  localparam int NT = NUM_THREADS;

  logic [N-1:0] s_req, a_req, a_prev, edge_vec, wr_bits;
  logic [N-1:0] polarity, trigger;
  logic [NT-1:0][N-1:0] mask, edge_latched, sw_latched;
  logic [NT-1:0][N-1:0] pending, masked, ack, swset;
  logic [N-1:0] sel_pending;
  logic [ID_WIDTH-1:0] sel_id;
  logic sel_any;
  logic thread_ok;
  logic [31:0] rd_data;
  ic_reg_e reg_sel;

  // Upper write bits are intentionally dropped.
  logic unused_write_bits;
  assign unused_write_bits = ^ic_write_val;

  function automatic logic [ID_WIDTH-1:0] lowest_id(input logic [N-1:0] v);
    lowest_id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lowest_id = ID_WIDTH'(i);
  endfunction

  interrupt_sync #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (interrupt_req),
    .q     (s_req)
  );

  assign a_req    = s_req ^ polarity;
  assign edge_vec = a_req & ~a_prev;
  assign wr_bits  = ic_write_val[N-1:0];
  assign reg_sel  = ic_reg_e'(ic_reg);

  // Non-power-of-two thread counts leave some index codes unused.
  if (NT == (1 << THREAD_W)) begin : g_idx_full
    assign thread_ok = 1'b1;
  end else begin : g_idx_part
    assign thread_ok = int'(ic_thread_idx) < NT;
  end

  for (genvar t = 0; t < NT; t++) begin : g_thread
    logic hit;
    assign hit      = ic_write_en && thread_ok && (ic_thread_idx == THREAD_W'(t));
    assign ack[t]   = (hit && reg_sel == IC_ACK)    ? wr_bits : '0;
    assign swset[t] = (hit && reg_sel == IC_SW_SET) ? wr_bits : '0;
    // Level lines bypass the edge latch, so ack cannot clear them.
    assign pending[t] = (trigger & a_req) | (~trigger & edge_latched[t]) | sw_latched[t];
    assign masked[t]  = pending[t] & mask[t];
    assign ic_interrupt_pending[t] = |masked[t];
    assign ic_interrupt_id[t]      = lowest_id(masked[t]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_prev       <= '0;
      edge_latched <= '0;
      sw_latched   <= '0;
    end else begin
      a_prev <= a_req;
      // Sets are OR-ed after the clear so a colliding set survives the ack.
      for (int t = 0; t < NT; t++) begin
        edge_latched[t] <= (edge_latched[t] & ~ack[t]) | edge_vec;
        sw_latched[t]   <= (sw_latched[t] & ~ack[t]) | swset[t];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '0;
      trigger  <= '0;
      polarity <= '0;
    end else if (ic_write_en) begin
      case (reg_sel)
        IC_MASK:     if (thread_ok) mask[ic_thread_idx] <= wr_bits;
        IC_TRIGGER:  trigger  <= wr_bits;
        IC_POLARITY: polarity <= wr_bits;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_pending = '0;
    sel_id      = '0;
    sel_any     = 1'b0;
    if (thread_ok) begin
      sel_pending = pending[ic_thread_idx];
      sel_id      = ic_interrupt_id[ic_thread_idx];
      sel_any     = ic_interrupt_pending[ic_thread_idx];
    end
  end

  always_comb begin
    rd_data = IC_NONE;
    case (reg_sel)
      IC_MASK:     rd_data = thread_ok ? 32'(mask[ic_thread_idx]) : 32'd0;
      IC_TRIGGER:  rd_data = 32'(trigger);
      IC_POLARITY: rd_data = 32'(polarity);
      IC_PENDING:  rd_data = 32'(sel_pending);
      IC_CLAIM:    rd_data = sel_any ? 32'(sel_id) : IC_NONE;
      default:     rd_data = IC_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ic_read_val <= '0;
    else if (ic_read_en) ic_read_val <= rd_data;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int N  = 16;
  localparam int NT = 4;
  localparam int S  = 2;
  localparam int IW = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] interrupt_req;
  logic ic_write_en, ic_read_en;
  logic [2:0] ic_reg;
  logic [TW-1:0] ic_thread_idx;
  logic [31:0] ic_write_val, ic_read_val;
  logic [NT-1:0] ic_interrupt_pending;
  logic [NT-1:0][IW-1:0] ic_interrupt_id;

  int vectors = 0;
  int miscompares = 0;

  interrupt_controller #(.NUM_INTERRUPTS(N), .NUM_THREADS(NT), .SYNC_STAGES(S)) dut (
    .clk                  (clk),
    .reset                (reset),
    .interrupt_req        (interrupt_req),
    .ic_write_en          (ic_write_en),
    .ic_read_en           (ic_read_en),
    .ic_reg               (ic_reg),
    .ic_thread_idx        (ic_thread_idx),
    .ic_write_val         (ic_write_val),
    .ic_read_val          (ic_read_val),
    .ic_interrupt_pending (ic_interrupt_pending),
    .ic_interrupt_id      (ic_interrupt_id)
  );

  always #5 clk = ~clk;

  // Reference model: a delay line of sampled raw inputs plus per-thread sets.
  logic [N-1:0] m_line [S];
  logic [N-1:0] m_pol, m_trig, m_aprev;
  logic [N-1:0] m_mask [NT];
  logic [N-1:0] m_el [NT];
  logic [N-1:0] m_sw [NT];
  logic [31:0]  m_rd;

  task automatic model_clear();
    for (int k = 0; k < S; k++) m_line[k] = '0;
    m_pol = '0; m_trig = '0; m_aprev = '0; m_rd = '0;
    for (int t = 0; t < NT; t++) begin
      m_mask[t] = '0; m_el[t] = '0; m_sw[t] = '0;
    end
  endtask

  function automatic logic [N-1:0] m_pend(input int t);
    logic [N-1:0] act;
    act = m_line[S-1] ^ m_pol;
    return (m_trig & act) | (~m_trig & m_el[t]) | m_sw[t];
  endfunction

  function automatic int m_first(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input int r, input int t);
    int f;
    case (r)
      0: return 32'(m_mask[t]);
      1: return 32'(m_trig);
      2: return 32'(m_pol);
      4: return 32'(m_pend(t));
      6: begin
        f = m_first(m_pend(t) & m_mask[t]);
        return (f < 0) ? 32'hffff_ffff : 32'(f);
      end
      default: return 32'hffff_ffff;
    endcase
  endfunction

  task automatic model_edge();
    logic [N-1:0] act, ed, w, ackv, setv;
    logic [31:0] nrd;
    int t_sel;
    t_sel = int'(ic_thread_idx);
    act = m_line[S-1] ^ m_pol;
    ed  = act & ~m_aprev;
    w   = ic_write_val[N-1:0];
    nrd = m_rd;
    if (ic_read_en) nrd = model_read(int'(ic_reg), t_sel);
    for (int t = 0; t < NT; t++) begin
      ackv = (ic_write_en && ic_reg == 3'd3 && t == t_sel) ? w : '0;
      setv = (ic_write_en && ic_reg == 3'd5 && t == t_sel) ? w : '0;
      m_el[t] = (m_el[t] & ~ackv) | ed;
      m_sw[t] = (m_sw[t] & ~ackv) | setv;
    end
    if (ic_write_en) begin
      if (ic_reg == 3'd0) m_mask[t_sel] = w;
      if (ic_reg == 3'd1) m_trig = w;
      if (ic_reg == 3'd2) m_pol = w;
    end
    m_aprev = act;
    for (int k = S - 1; k > 0; k--) m_line[k] = m_line[k-1];
    m_line[0] = interrupt_req;
    m_rd = nrd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NT-1:0] ep;
    logic [NT-1:0][IW-1:0] eid;
    int f;
    for (int t = 0; t < NT; t++) begin
      f = m_first(m_pend(t) & m_mask[t]);
      ep[t]  = (f >= 0);
      eid[t] = (f >= 0) ? IW'(f) : '0;
    end
    chk("pending", 32'(ic_interrupt_pending), 32'(ep));
    chk("id", 32'(ic_interrupt_id), 32'(eid));
    chk("read_val", ic_read_val, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wr(input int r, input int t, input logic [31:0] v);
    ic_write_en = 1'b1; ic_reg = 3'(r); ic_thread_idx = TW'(t); ic_write_val = v;
    tick();
    ic_write_en = 1'b0;
  endtask

  task automatic rd(input int r, input int t);
    ic_read_en = 1'b1; ic_reg = 3'(r); ic_thread_idx = TW'(t);
    tick();
    ic_read_en = 1'b0;
  endtask

  task automatic ack_all();
    for (int t = 0; t < NT; t++) wr(3, t, 32'hffff);
  endtask

  initial begin
    reset = 1'b1; interrupt_req = '0; ic_write_en = 1'b0; ic_read_en = 1'b0;
    ic_reg = '0; ic_thread_idx = '0; ic_write_val = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pending", 32'(ic_interrupt_pending), 32'd0);
    chk("reset_id", 32'(ic_interrupt_id), 32'd0);
    chk("reset_read", ic_read_val, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Edge latch and ack
    wr(0, 0, 32'h0001);
    interrupt_req[0] = 1'b1;
    tick();
    interrupt_req[0] = 1'b0;
    tick();
    chk("edge_not_yet", 32'(ic_interrupt_pending[0]), 32'd0);
    tick();
    chk("edge_latched", 32'(ic_interrupt_pending[0]), 32'd1);
    chk("edge_id", 32'(ic_interrupt_id[0]), 32'd0);
    wr(3, 0, 32'h0001);
    chk("edge_acked", 32'(ic_interrupt_pending[0]), 32'd0);

    // Level trigger
    wr(1, 0, 32'h0004);
    wr(0, 1, 32'h0004);
    interrupt_req[2] = 1'b1;
    repeat (3) tick();
    chk("level_high", 32'(ic_interrupt_pending[1]), 32'd1);
    wr(3, 1, 32'h0004);
    chk("level_ack_noeffect", 32'(ic_interrupt_pending[1]), 32'd1);
    interrupt_req[2] = 1'b0;
    tick();
    chk("level_lag", 32'(ic_interrupt_pending[1]), 32'd1);
    tick();
    chk("level_low", 32'(ic_interrupt_pending[1]), 32'd0);

    // Priority and claim
    ack_all();
    wr(5, 3, 32'h0120);
    wr(0, 3, 32'hffff);
    chk("prio_id5", 32'(ic_interrupt_id[3]), 32'd5);
    rd(6, 3);
    chk("claim5", ic_read_val, 32'd5);
    wr(3, 3, 32'h0020);
    chk("prio_id8", 32'(ic_interrupt_id[3]), 32'd8);
    wr(3, 3, 32'h0100);
    rd(6, 3);
    chk("claim_none", ic_read_val, 32'hffff_ffff);
    rd(7, 0);
    chk("read_idx7", ic_read_val, 32'hffff_ffff);

    // Polarity
    ack_all();
    wr(0, 0, 32'h0008);
    wr(2, 0, 32'h0008);
    chk("pol_not_yet", 32'(ic_interrupt_pending[0]), 32'd0);
    tick();
    chk("pol_edge", 32'(ic_interrupt_pending[0]), 32'd1);
    chk("pol_id", 32'(ic_interrupt_id[0]), 32'd3);
    wr(3, 0, 32'h0008);
    chk("pol_acked", 32'(ic_interrupt_pending[0]), 32'd0);
    interrupt_req[3] = 1'b1;
    repeat (3) tick();
    interrupt_req[3] = 1'b0;
    repeat (3) tick();
    chk("pol_fall_edge", 32'(ic_interrupt_pending[0]), 32'd1);
    rd(2, 0);
    chk("read_pol", ic_read_val, 32'h0008);

    // Edge/ack collision
    ack_all();
    wr(0, 0, 32'h0002);
    interrupt_req[1] = 1'b1;
    tick();
    tick();
    wr(3, 0, 32'h0002);
    chk("collide_edge", 32'(ic_interrupt_pending[0]), 32'd1);
    chk("collide_id", 32'(ic_interrupt_id[0]), 32'd1);

    // Reset mid-operation with a read in flight
    ic_read_en = 1'b1; ic_reg = 3'd4; ic_thread_idx = '0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_pending", 32'(ic_interrupt_pending), 32'd0);
    chk("midrst_id", 32'(ic_interrupt_id), 32'd0);
    chk("midrst_read", ic_read_val, 32'd0);
    ic_read_en = 1'b0;
    interrupt_req = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("post_rst_read", ic_read_val, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        interrupt_req = interrupt_req ^ (N'(1) << $urandom_range(0, N - 1));
      ic_write_en = 1'b0; ic_read_en = 1'b0;
      ic_reg = 3'($urandom_range(0, 7));
      ic_thread_idx = TW'($urandom_range(0, NT - 1));
      ic_write_val = $urandom;
      case ($urandom_range(0, 3))
        1: ic_write_en = 1'b1;
        2, 3: ic_read_en = 1'b1;
        default: ;
      endcase
      if (ic_write_en && ic_reg == 3'd2 && $urandom_range(0, 3) != 0) ic_write_en = 1'b0;
      tick();
    end
    ic_write_en = 1'b0; ic_read_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
